// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle barrel shifter, one power-of-two stage per clock
module shift_sequencer #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [4:0]  shiftamt_i,
    input  logic [31:0] data_i,
    output logic [31:0] result_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  amt_q, amt_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  k_q, k_d;
    logic [4:0]  low_mask;
    logic        last_stage;

    // One barrel stage: shift by 2^k according to the latched operation.
    function automatic logic [31:0] stage_shift(input logic [31:0] a,
                                                input logic [1:0]  o,
                                                input logic [2:0]  k);
        logic [5:0] n;
        n = 6'd1 << k;
        case (o)
            OP_SLL:  return a << n;
            OP_SRL:  return a >> n;
            OP_SRA:  return 32'($signed(a) >>> n);
            OP_ROR:  return (a >> n) | (a << (6'd32 - n));
            default: return a;
        endcase
    endfunction

    // Bits of amt below the current stage; all-zero means nothing is left to do.
    assign low_mask   = (5'd1 << k_q) - 5'd1;
    assign last_stage = (k_q == 3'd0) || (EARLY_EXIT && ((amt_q & low_mask) == 5'd0));

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            acc_q   <= 32'd0;
            amt_q   <= 5'd0;
            op_q    <= 2'd0;
            k_q     <= 3'd4;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            op_q    <= op_d;
            k_q     <= k_d;
        end
    end

    // Next-state: accept in IDLE/DONE, walk stages 4..0 in SHIFT.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        op_d    = op_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d   = data_i;
                    amt_d   = shiftamt_i;
                    op_d    = op_i;
                    k_d     = 3'd4;
                    state_d = (EARLY_EXIT && (shiftamt_i == 5'd0)) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (amt_q[k_q]) begin
                    acc_d = stage_shift(acc_q, op_q, k_q);
                end
                k_d = k_q - 3'd1;
                if (last_stage) begin
                    k_d     = 3'd4;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    acc_d   = data_i;
                    amt_d   = shiftamt_i;
                    op_d    = op_i;
                    k_d     = 3'd4;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign result_o = acc_q;
    assign busy_o   = (state_q == S_SHIFT);
    assign done_o   = (state_q == S_DONE);

endmodule
